// File: rtl/processor_pkg.sv
// rtl/processor_pkg.sv - shared destination encoding and channel state types
package processor_pkg;

    localparam int NUM_DEST = 5;

    typedef enum logic [2:0] {
        DEST_WB,
        DEST_MEM,
        DEST_BR,
        DEST_IO,
        DEST_DBG
    } dest_sel_t;

    typedef enum logic {
        CH_EMPTY,
        CH_FULL
    } ch_state_t;

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry valid/ready holding register for one output channel
module demux_slot
    import processor_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  slot_ready
);

    ch_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // load is only raised while slot_ready is high, so FULL+load implies a drain
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            CH_EMPTY: begin
                if (load) begin
                    state_d = CH_FULL;
                    data_d  = load_data;
                end
            end
            CH_FULL: begin
                if (load) begin
                    data_d = load_data;
                end else if (out_ready) begin
                    state_d = CH_EMPTY;
                end
            end
            default: state_d = CH_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CH_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign out_valid  = (state_q == CH_FULL);
    assign out_data   = data_q;
    assign slot_ready = (state_q == CH_EMPTY) | out_ready;

endmodule

// File: rtl/demux_router.sv
// rtl/demux_router.sv - registered 1-to-5 result demultiplexer with drop accounting
module demux_router
    import processor_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_OUT    = 5,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic [2:0]                    in_sel,
    output logic [NUM_OUT-1:0]            out_valid,
    input  logic [NUM_OUT-1:0]            out_ready,
    output logic [NUM_OUT*DATA_WIDTH-1:0] out_data,
    output logic                          bad_sel,
    output logic [CNT_WIDTH-1:0]          drop_count
);

    logic [NUM_OUT-1:0]   slot_ready;
    logic [NUM_OUT-1:0]   load;
    logic [7:0]           ready_ext;
    logic                 sel_ok;
    logic                 drop;
    logic                 bad_sel_q, bad_sel_d;
    logic [CNT_WIDTH-1:0] drop_count_q, drop_count_d;

    assign sel_ok = (in_sel < 3'(NUM_DEST));

    // Unused select codes read as always-ready so bad words are swallowed
    always_comb begin
        ready_ext                = '1;
        ready_ext[NUM_OUT-1:0]   = slot_ready;
    end

    assign in_ready = ready_ext[in_sel];
    assign drop     = in_valid & ~sel_ok;

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
        assign load[k] = in_valid & in_ready & (in_sel == 3'(k));

        demux_slot #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .load      (load[k]),
            .load_data (in_data),
            .out_ready (out_ready[k]),
            .out_valid (out_valid[k]),
            .out_data  (out_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .slot_ready(slot_ready[k])
        );
    end

    always_comb begin
        bad_sel_d    = drop;
        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != '1)) begin
            drop_count_d = drop_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bad_sel_q    <= 1'b0;
            drop_count_q <= '0;
        end else begin
            bad_sel_q    <= bad_sel_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign bad_sel    = bad_sel_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_demux_router.sv
// tb/tb_demux_router.sv - directed self-checking bench for demux_router
module tb_demux_router;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [2:0]  in_sel;
    logic [4:0]  out_valid;
    logic [4:0]  out_ready;
    logic [79:0] out_data;
    logic        bad_sel;
    logic [7:0]  drop_count;

    int total = 0;
    int bad   = 0;
    int aaaa_seen = 0;

    always #5 clk = ~clk;

    demux_router dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .bad_sel   (bad_sel),
        .drop_count(drop_count)
    );

    always @(posedge clk) begin
        if (!reset && out_valid[1] && out_ready[1] && out_data[31:16] == 16'hAAAA)
            aaaa_seen++;
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] slice(input int k);
        return out_data[k*16 +: 16];
    endfunction

    task automatic offer(input logic [2:0] sel, input logic [15:0] data);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_sel = 3'd0; in_data = 16'h0; out_ready = 5'h1F;
        tick(); tick();
        check("rst_valid", out_valid, 5'b0);
        check("rst_data", out_data, 80'h0);
        check("rst_bad_sel", bad_sel, 1'b0);
        check("rst_drop", drop_count, 8'h0);
        reset = 1'b0;
        tick();

        // idle channel load
        offer(3'd2, 16'hBEEF);
        check("idle_ready", in_ready, 1'b1);
        tick(); in_valid = 1'b0;
        check("idle_valid", out_valid, 5'b00100);
        check("idle_data2", slice(2), 16'hBEEF);
        check("idle_others", out_data & ~{32'h0, 16'hFFFF, 32'h0}, 80'h0);
        tick();
        check("idle_drained", out_valid, 5'b0);

        // back-pressure on channel 0 does not block channel 3
        out_ready = 5'b0;
        offer(3'd0, 16'h1111);
        tick();
        offer(3'd0, 16'h2222);
        check("bp_ready0", in_ready, 1'b0);
        tick();
        check("bp_hold0", slice(0), 16'h1111);
        check("bp_valid0", out_valid, 5'b00001);
        offer(3'd3, 16'h3333);
        check("bp_ready3", in_ready, 1'b1);
        tick(); in_valid = 1'b0;
        check("bp_valid03", out_valid, 5'b01001);
        check("bp_data3", slice(3), 16'h3333);
        check("bp_still0", slice(0), 16'h1111);
        out_ready = 5'h1F;
        tick();
        check("bp_drained", out_valid, 5'b0);

        // simultaneous drain and reload on channel 1
        out_ready = 5'b0;
        offer(3'd1, 16'hAAAA);
        tick();
        out_ready = 5'b00010;
        offer(3'd1, 16'h5555);
        check("sim_ready", in_ready, 1'b1);
        tick(); in_valid = 1'b0;
        check("sim_valid1", out_valid[1], 1'b1);
        check("sim_data1", slice(1), 16'h5555);
        tick();
        check("sim_aaaa_once", aaaa_seen, 1);
        check("sim_drained", out_valid, 5'b0);

        // invalid select: drop counter saturates
        out_ready = 5'h1F;
        for (int i = 0; i < 300; i++) begin
            offer(3'd6, 16'(i));
            check("inv_ready", in_ready, 1'b1);
            tick();
            check("inv_bad_sel", bad_sel, 1'b1);
            check("inv_drop", drop_count, (i + 1 > 255) ? 8'hFF : 8'(i + 1));
            check("inv_no_valid", out_valid, 5'b0);
        end
        in_valid = 1'b0;
        tick();
        check("inv_bad_clear", bad_sel, 1'b0);
        check("inv_drop_hold", drop_count, 8'hFF);

        // reset mid-operation
        reset = 1'b1; tick(); reset = 1'b0;
        check("r2_drop", drop_count, 8'h0);
        out_ready = 5'b0;
        offer(3'd0, 16'h0A0A); tick();
        offer(3'd4, 16'h0B0B); tick();
        for (int i = 0; i < 7; i++) begin
            offer(3'd5, 16'h0); tick();
        end
        check("mid_drop7", drop_count, 8'd7);
        check("mid_valid", out_valid, 5'b10001);
        reset = 1'b1;
        offer(3'd1, 16'h1234);
        tick();
        reset = 1'b0; in_valid = 1'b0;
        check("mid_rst_valid", out_valid, 5'b0);
        check("mid_rst_data", out_data, 80'h0);
        check("mid_rst_drop", drop_count, 8'h0);
        check("mid_rst_bad", bad_sel, 1'b0);
        offer(3'd1, 16'h0C0C);
        tick(); in_valid = 1'b0;
        check("post_rst_valid", out_valid, 5'b00010);
        check("post_rst_data", slice(1), 16'h0C0C);

        // streaming on channel 4
        out_ready = 5'h1F;
        for (int i = 1; i <= 8; i++) begin
            offer(3'd4, 16'(i));
            check("str_ready", in_ready, 1'b1);
            tick();
            check("str_valid4", out_valid[4], 1'b1);
            check("str_data4", slice(4), 16'(i));
        end
        in_valid = 1'b0;
        tick();
        check("str_done", out_valid, 5'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
